int_div_vec: RTL and testbench

Parametrised, lane-parallel iterative integer divider for the fpunit vector datapath. It accepts L lanes of N-bit numerator/denominator pairs under a valid/ready handshake and runs one radix-2 restoring division per lane in lockstep. Lanes can be divided as signed or unsigned. Each lane reports divide-by-zero explicitly instead of gating its enable. It replaces the fixed-latency vendor-divider array where the unit needs back-pressure, signed mode and defined zero-denominator results.

---
 rtl/int_div_vec_pkg.sv | 25 ++
 rtl/int_div_vec_if.sv | 27 ++
 rtl/int_div_vec_lane.sv | 85 ++++++++
 rtl/int_div_vec.sv | 98 +++++++++
 tb/tb_int_div_vec.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/int_div_vec_pkg.sv
// Shared types and elaboration helpers for the lane-parallel integer divider.
// Holds the FSM state encoding, the counter width function and the lane slice helper.
package int_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return w;
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/int_div_vec_if.sv
// Operand/result handshake bundle for int_div_vec.
// The master side supplies operands and consumes results; the divider is the slave.
interface int_div_vec_if #(
    parameter int N = 32,
    parameter int L = 4
);
    logic           in_valid;
    logic           in_ready;
    logic           is_signed;
    logic [N*L-1:0] numer;
    logic [N*L-1:0] denom;
    logic           out_valid;
    logic           out_ready;
    logic [N*L-1:0] quotient;
    logic [N*L-1:0] remainder;
    logic [L-1:0]   div_zero;

    modport master (
        output in_valid, is_signed, numer, denom, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, is_signed, numer, denom, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/int_div_vec_lane.sv
// One lane of the restoring divider: magnitude datapath, sign/zero capture and result fix-up.
// Sequenced entirely by the load/step/fix strobes from the shared FSM.
module int_div_lane #(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_step,
    input  logic         i_fix,
    input  logic         i_signed,
    input  logic [N-1:0] i_numer,
    input  logic [N-1:0] i_denom,
    output logic [N-1:0] o_quot,
    output logic [N-1:0] o_rem,
    output logic         o_zero
);
    logic [N:0]   r_rem;
    logic [N-1:0] r_q;
    logic [N-1:0] r_d;
    logic [N-1:0] r_numer;
    logic         r_sign_q;
    logic         r_sign_r;
    logic         r_zero;

    logic         w_n_neg;
    logic         w_d_neg;
    logic [N-1:0] w_n_abs;
    logic [N-1:0] w_d_abs;
    logic [N+1:0] w_shift;
    logic [N:0]   w_trial;
    logic         w_fits;

    assign w_n_neg = i_signed & i_numer[N-1];
    assign w_d_neg = i_signed & i_denom[N-1];
    assign w_n_abs = w_n_neg ? -i_numer : i_numer;
    assign w_d_abs = w_d_neg ? -i_denom : i_denom;

    // Partial remainder never exceeds the divisor, so the shifted value fits in N+1 bits
    assign w_shift = {r_rem, r_q[N-1]};
    assign w_fits  = (w_shift >= {2'b00, r_d});
    assign w_trial = w_shift[N:0] - {1'b0, r_d};

    // Lane state: operand capture, one restoring step per strobe, then signed/zero fix-up
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem    <= '0;
            r_q      <= '0;
            r_d      <= '0;
            r_numer  <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_zero   <= 1'b0;
            o_quot   <= '0;
            o_rem    <= '0;
            o_zero   <= 1'b0;
        end else if (i_load) begin
            r_rem    <= '0;
            r_q      <= w_n_abs;
            r_d      <= w_d_abs;
            r_numer  <= i_numer;
            r_sign_q <= w_n_neg ^ w_d_neg;
            r_sign_r <= w_n_neg;
            r_zero   <= (i_denom == '0);
        end else if (i_step) begin
            if (w_fits) begin
                r_rem <= w_trial;
                r_q   <= {r_q[N-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[N:0];
                r_q   <= {r_q[N-2:0], 1'b0};
            end
        end else if (i_fix) begin
            if (r_zero) begin
                o_quot <= '1;
                o_rem  <= r_numer;
            end else begin
                o_quot <= r_sign_q ? -r_q : r_q;
                o_rem  <= r_sign_r ? -r_rem[N-1:0] : r_rem[N-1:0];
            end
            o_zero <= r_zero;
        end
    end

endmodule

// File: rtl/int_div_vec.sv
// L-lane lockstep iterative integer divider with valid/ready handshake and clock enable.
// A single FSM and bit counter sequence all lanes; outputs hold from FIX until transferred.
module int_div_vec
    import int_div_pkg::*;
#(
    parameter int N = 32,
    parameter int L = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    int_div_vec_if.slave  io_div
);
    localparam int            CW       = clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e         r_state;
    logic [CW-1:0]  r_cnt;

    logic           w_in_ready;
    logic           w_accept;
    logic           w_step;
    logic           w_fix;
    logic [N*L-1:0] w_quot;
    logic [N*L-1:0] w_rem;
    logic [L-1:0]   w_zero;

    assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && io_div.out_ready);
    assign w_accept   = i_clk_en && io_div.in_valid && w_in_ready;
    assign w_step     = i_clk_en && (r_state == CALC);
    assign w_fix      = i_clk_en && (r_state == FIX);

    assign io_div.in_ready  = w_in_ready;
    assign io_div.out_valid = (r_state == DONE);
    assign io_div.quotient  = w_quot;
    assign io_div.remainder = w_rem;
    assign io_div.div_zero  = w_zero;

    // Shared sequencer; in DONE an accept implies a transfer, enabling back-to-back bundles
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (i_clk_en) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= CALC;
                        r_cnt   <= CNT_LAST;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                FIX: begin
                    r_state <= DONE;
                end
                DONE: begin
                    if (w_accept) begin
                        r_state <= CALC;
                        r_cnt   <= CNT_LAST;
                    end else if (io_div.out_ready) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < L; g++) begin : g_lane
        int_div_lane #(.N(N)) u_lane (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_load   (w_accept),
            .i_step   (w_step),
            .i_fix    (w_fix),
            .i_signed (io_div.is_signed),
            .i_numer  (io_div.numer[lane_lo(g, N) +: N]),
            .i_denom  (io_div.denom[lane_lo(g, N) +: N]),
            .o_quot   (w_quot[lane_lo(g, N) +: N]),
            .o_rem    (w_rem[lane_lo(g, N) +: N]),
            .o_zero   (w_zero[g])
        );
    end

endmodule

// File: tb/tb_int_div_vec.sv
// Self-checking bench for int_div_vec: directed spec vectors plus randomized bundles
// checked against a plain-arithmetic truncating-division reference model.
module tb_int_div_vec;
    localparam int N = 32;
    localparam int L = 4;
    localparam logic [N-1:0] MIN_V = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    int   checks = 0;
    int   errors = 0;

    logic [N-1:0] vn [L];
    logic [N-1:0] vd [L];
    logic         vs;

    int_div_vec_if #(.N(N), .L(L)) dif ();

    int_div_vec #(.N(N), .L(L)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clk_en (clk_en),
        .io_div   (dif)
    );

    always #5 clk = ~clk;

    // Reference: truncating division on wide integers, zero denominator handled explicitly
    function automatic void ref_div(input logic [N-1:0] n, input logic [N-1:0] d, input logic sgn,
                                    output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
        longint nn, dd;
        z = (d == '0);
        if (z) begin
            q = '1;
            r = n;
        end else begin
            if (sgn) begin
                nn = longint'(signed'(n));
                dd = longint'(signed'(d));
            end else begin
                nn = longint'(n);
                dd = longint'(d);
            end
            q = N'(nn / dd);
            r = N'(nn % dd);
        end
    endfunction

    function automatic logic [N-1:0] pick_val(input bit allow_zero);
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       return allow_zero ? '0 : 32'd1;
            1:       return MIN_V;
            2:       return '1;
            3:       return N'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic load_inputs();
        dif.is_signed = vs;
        for (int i = 0; i < L; i++) begin
            dif.numer[i*N +: N] = vn[i];
            dif.denom[i*N +: N] = vd[i];
        end
    endtask

    task automatic drive_bundle();
        int w;
        @(negedge clk);
        load_inputs();
        dif.in_valid = 1'b1;
        w = 0;
        while (!dif.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!dif.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", dif.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        dif.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!dif.out_valid && lat < 200);
        if (!dif.out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: out_valid=%b after %0d edges, required 1", dif.out_valid, lat);
        end
    endtask

    task automatic consume();
        dif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_en = 1'b1;
        dif.in_valid = 1'b0;
        dif.out_ready = 1'b0;
        dif.is_signed = 1'b0;
        dif.numer = '0;
        dif.denom = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1 || dif.quotient !== '0 ||
            dif.remainder !== '0 || dif.div_zero !== '0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b q=%h r=%h dz=%b, required 0 1 0 0 0",
                     dif.out_valid, dif.in_ready, dif.quotient, dif.remainder, dif.div_zero);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        vs = 1'b0;
        for (int i = 0; i < L; i++) begin
            vn[i] = $urandom;
            vd[i] = $urandom;
        end
        drive_bundle();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_calc: out_valid=%b in_ready=%b, required 0 1", dif.out_valid, dif.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < L; i++) begin
            vn[i] = 32'd100;
            vd[i] = 32'd7;
        end
        drive_bundle();
        wait_valid(lat);
        for (int i = 0; i < L; i++) begin
            checks++;
            if (dif.quotient[i*N +: N] !== 32'd14 || dif.remainder[i*N +: N] !== 32'd2) begin
                errors++;
                $display("FAIL after_reset lane %0d: q=%0d r=%0d, required q=14 r=2",
                         i, dif.quotient[i*N +: N], dif.remainder[i*N +: N]);
            end
        end
        consume();
    endtask

    task automatic run_directed(input string name);
        int lat;
        logic [N-1:0] eq, er;
        logic ez;
        drive_bundle();
        wait_valid(lat);
        checks++;
        if (lat !== N + 1) begin
            errors++;
            $display("FAIL %s latency: %0d edges, required %0d", name, lat, N + 1);
        end
        for (int i = 0; i < L; i++) begin
            ref_div(vn[i], vd[i], vs, eq, er, ez);
            checks++;
            if (dif.quotient[i*N +: N] !== eq || dif.remainder[i*N +: N] !== er || dif.div_zero[i] !== ez) begin
                errors++;
                $display("FAIL %s lane %0d: q=%h r=%h dz=%b, required q=%h r=%h dz=%b", name, i,
                         dif.quotient[i*N +: N], dif.remainder[i*N +: N], dif.div_zero[i], eq, er, ez);
            end
        end
        consume();
        checks++;
        if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_transfer: out_valid=%b in_ready=%b, required 0 1",
                     name, dif.out_valid, dif.in_ready);
        end
    endtask

    task automatic test_unsigned();
        vs = 1'b0;
        vn[0] = 32'd100;       vd[0] = 32'd7;
        vn[1] = 32'hFFFF_FFFF; vd[1] = 32'd1;
        vn[2] = 32'd5;         vd[2] = 32'd9;
        vn[3] = 32'd0;         vd[3] = 32'd3;
        run_directed("unsigned");
    endtask

    task automatic test_signed();
        vs = 1'b1;
        vn[0] = 32'hFFFF_FFF9; vd[0] = 32'd2;
        vn[1] = 32'd7;         vd[1] = 32'hFFFF_FFFE;
        vn[2] = 32'hFFFF_FFF9; vd[2] = 32'hFFFF_FFFE;
        vn[3] = MIN_V;         vd[3] = 32'hFFFF_FFFF;
        run_directed("signed");
    endtask

    task automatic test_div_zero();
        vs = 1'b1;
        vn[0] = 32'd42;        vd[0] = 32'd0;
        vn[1] = 32'hFFFF_FFFB; vd[1] = 32'd0;
        vn[2] = 32'd9;         vd[2] = 32'd3;
        vn[3] = 32'd0;         vd[3] = 32'd0;
        run_directed("div_zero");
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            vs = 1'($urandom_range(0, 1));
            for (int i = 0; i < L; i++) begin
                vn[i] = pick_val(1'b1);
                vd[i] = pick_val(1'b1);
            end
            run_directed("random");
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [N*L-1:0] snap_q, snap_r;
        logic [N-1:0] eq, er;
        logic ez;
        vs = 1'b0;
        for (int i = 0; i < L; i++) begin
            vn[i] = $urandom;
            vd[i] = N'($urandom_range(1, 1000));
        end
        drive_bundle();
        wait_valid(lat);
        snap_q = dif.quotient;
        snap_r = dif.remainder;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0 ||
                dif.quotient !== snap_q || dif.remainder !== snap_r) begin
                errors++;
                $display("FAIL backpressure cycle %0d: out_valid=%b in_ready=%b held=%b, required 1 0 1",
                         c, dif.out_valid, dif.in_ready, (dif.quotient === snap_q && dif.remainder === snap_r));
            end
        end
        vs = 1'b1;
        for (int i = 0; i < L; i++) begin
            vn[i] = pick_val(1'b0);
            vd[i] = pick_val(1'b1);
        end
        load_inputs();
        dif.in_valid = 1'b1;
        dif.out_ready = 1'b1;
        #1;
        checks++;
        if (dif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b in_ready: %b, required 1", dif.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        dif.in_valid = 1'b0;
        dif.out_ready = 1'b0;
        checks++;
        if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b accepted: out_valid=%b in_ready=%b, required 0 0", dif.out_valid, dif.in_ready);
        end
        wait_valid(lat);
        checks++;
        if (lat !== N + 1) begin
            errors++;
            $display("FAIL b2b latency: %0d edges, required %0d", lat, N + 1);
        end
        for (int i = 0; i < L; i++) begin
            ref_div(vn[i], vd[i], vs, eq, er, ez);
            checks++;
            if (dif.quotient[i*N +: N] !== eq || dif.remainder[i*N +: N] !== er || dif.div_zero[i] !== ez) begin
                errors++;
                $display("FAIL b2b lane %0d: q=%h r=%h dz=%b, required q=%h r=%h dz=%b", i,
                         dif.quotient[i*N +: N], dif.remainder[i*N +: N], dif.div_zero[i], eq, er, ez);
            end
        end
        consume();
    endtask

    task automatic test_stall();
        int lat, lows;
        logic [N-1:0] eq, er;
        logic ez;
        vs = 1'b1;
        for (int i = 0; i < L; i++) begin
            vn[i] = pick_val(1'b0);
            vd[i] = pick_val(1'b1);
        end
        drive_bundle();
        lat = 0;
        lows = 0;
        while (!dif.out_valid && lat < 300) begin
            clk_en = (lat == 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (!clk_en) lows++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        clk_en = 1'b1;
        checks++;
        if (lat !== N + 1 + lows) begin
            errors++;
            $display("FAIL stall latency: %0d edges with %0d stalled, required %0d", lat, lows, N + 1 + lows);
        end
        for (int i = 0; i < L; i++) begin
            ref_div(vn[i], vd[i], vs, eq, er, ez);
            checks++;
            if (dif.quotient[i*N +: N] !== eq || dif.remainder[i*N +: N] !== er || dif.div_zero[i] !== ez) begin
                errors++;
                $display("FAIL stall lane %0d: q=%h r=%h dz=%b, required q=%h r=%h dz=%b", i,
                         dif.quotient[i*N +: N], dif.remainder[i*N +: N], dif.div_zero[i], eq, er, ez);
            end
        end
        clk_en = 1'b0;
        dif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dif.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_transfer: out_valid=%b with clk_en low, required 1", dif.out_valid);
        end
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.out_ready = 1'b0;
        checks++;
        if (dif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: out_valid=%b, required 0", dif.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_calc();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_random();
        test_back_to_back();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
